// File: rtl/halve_tokens_if.sv
`default_nettype none
// ============================================================================
//  Module      : halve_tokens_if
//  Description : Stream and status signals of the token-halving decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface halve_tokens_if #(
    parameter int CNT_W = 16
);
    logic             valid_in;
    logic             b;
    logic             valid_out;
    logic             a;
    logic             odd_error;
    logic             overflow;
    logic [CNT_W-1:0] token_count;

    // master feeds the doubled stream and observes the decoded result
    modport master (
        output valid_in, b,
        input  valid_out, a, odd_error, overflow, token_count
    );

    modport slave (
        input  valid_in, b,
        output valid_out, a, odd_error, overflow, token_count
    );
endinterface
`default_nettype wire

// File: rtl/halve_tokens.sv
`default_nettype none
// ============================================================================
//  Module      : halve_tokens
//  Description : Decodes a token-doubled serial stream back to one token per
//                pair, flagging odd-length and over-capacity runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module halve_tokens #(
    parameter int MAX_TOKENS = 200,
    parameter int CNT_W      = 16
) (
    input  wire            clk,
    input  wire            rst,
    halve_tokens_if.slave  bus
);
    localparam int                 c_RUN_W   = $clog2(2 * MAX_TOKENS + 2);
    localparam logic [c_RUN_W-1:0] c_RUN_CAP = c_RUN_W'(2 * MAX_TOKENS);
    localparam logic [c_RUN_W-1:0] c_RUN_SAT = c_RUN_W'(2 * MAX_TOKENS + 1);

    logic               r_valid_out;
    logic               r_a;
    logic               r_odd_error;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_count;
    logic               r_parity;
    logic [c_RUN_W-1:0] r_run_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_a         <= 1'b0;
            r_odd_error <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
            r_parity    <= 1'b0;
            r_run_len   <= '0;
        end else begin
            r_valid_out <= bus.valid_in;
            r_a         <= 1'b0;
            // idle cycles leave the run open so gaps never split a pair
            if (bus.valid_in) begin
                if (bus.b) begin
                    r_a      <= r_parity;
                    r_parity <= ~r_parity;
                    if (r_run_len != c_RUN_SAT) begin
                        r_run_len <= r_run_len + c_RUN_W'(1);
                    end
                    if (r_parity) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (r_run_len == c_RUN_CAP) begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    if (r_parity) begin
                        r_odd_error <= 1'b1;
                    end
                    r_parity  <= 1'b0;
                    r_run_len <= '0;
                end
            end
        end
    end

    assign bus.valid_out   = r_valid_out;
    assign bus.a           = r_a;
    assign bus.odd_error   = r_odd_error;
    assign bus.overflow    = r_overflow;
    assign bus.token_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_halve_tokens.sv
`default_nettype none
// ============================================================================
//  Module      : tb_halve_tokens
//  Description : Self-checking bench for halve_tokens (CNT_W=16 and CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_halve_tokens;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0] sb[$];
    logic [1:0] exp_va;

    halve_tokens_if #(.CNT_W(16)) bus ();
    halve_tokens_if #(.CNT_W(4))  bus4 ();

    halve_tokens #(.MAX_TOKENS(200), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    halve_tokens #(.MAX_TOKENS(200), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // drive one cycle on the 16-bit instance and queue the expected {valid_out, a}
    task automatic drive(input logic v, input logic bv, input logic ea);
        @(negedge clk);
        bus.valid_in = v;
        bus.b        = bv;
        sb.push_back({v, ea});
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic bv, input logic ea);
        @(negedge clk);
        bus4.valid_in = v;
        bus4.b        = bv;
        sb.push_back({v, ea});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.b         = 1'b0;
        bus4.valid_in = 1'b0;
        bus4.b        = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.valid_out, bus.a, bus.odd_error, bus.overflow} !== 4'b0000 || bus.token_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got vo/a/odd/ovf=%b%b%b%b cnt=%0d required 0000 cnt=0",
                     bus.valid_out, bus.a, bus.odd_error, bus.overflow, bus.token_count);
        end
        checks++;
        if ({bus4.valid_out, bus4.a, bus4.odd_error, bus4.overflow} !== 4'b0000 || bus4.token_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_state4: got vo/a/odd/ovf=%b%b%b%b cnt=%0d required 0000 cnt=0",
                     bus4.valid_out, bus4.a, bus4.odd_error, bus4.overflow, bus4.token_count);
        end
    endtask

    task automatic test_canonical();
        logic [25:0] bseq;
        logic [25:0] aseq;
        bseq = 26'b11011011110111111001111110;
        aseq = 26'b01001001010010101000101010;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            drive(1'b1, bseq[25-i], aseq[25-i]);
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va) begin
                failures++;
                $display("FAIL canon_bit%0d: got vo,a=%b%b required %b", i, bus.valid_out, bus.a, exp_va);
            end
        end
        checks++;
        if (bus.token_count !== 16'd10 || bus.odd_error !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL canon_final: got cnt=%0d odd=%b ovf=%b required cnt=10 odd=0 ovf=0",
                     bus.token_count, bus.odd_error, bus.overflow);
        end
    endtask

    task automatic test_odd_run();
        logic [3:0] bseq;
        logic [3:0] aseq;
        bseq = 4'b1110;
        aseq = 4'b0100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bseq[3-i], aseq[3-i]);
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va || bus.odd_error !== (i == 3)) begin
                failures++;
                $display("FAIL odd_bit%0d: got vo,a=%b%b odd=%b required %b odd=%b",
                         i, bus.valid_out, bus.a, bus.odd_error, exp_va, (i == 3));
            end
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va || bus.odd_error !== 1'b1) begin
                failures++;
                $display("FAIL odd_sticky%0d: got vo,a=%b%b odd=%b required %b odd=1",
                         i, bus.valid_out, bus.a, bus.odd_error, exp_va);
            end
        end
        do_reset();
        checks++;
        if (bus.odd_error !== 1'b0) begin
            failures++;
            $display("FAIL odd_cleared: got odd=%b required 0", bus.odd_error);
        end
    endtask

    task automatic test_valid_gaps();
        logic [5:0] vseq;
        logic [5:0] bseq;
        logic [5:0] aseq;
        vseq = 6'b100011;
        bseq = 6'b100010;
        aseq = 6'b000010;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(vseq[5-i], bseq[5-i], aseq[5-i]);
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va) begin
                failures++;
                $display("FAIL gap_cycle%0d: got vo,a=%b%b required %b", i, bus.valid_out, bus.a, exp_va);
            end
        end
        checks++;
        if (bus.odd_error !== 1'b0 || bus.token_count !== 16'd1) begin
            failures++;
            $display("FAIL gap_final: got odd=%b cnt=%0d required odd=0 cnt=1", bus.odd_error, bus.token_count);
        end
    endtask

    task automatic test_capacity();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'b1, 1'b1, logic'(i % 2));
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va || bus.overflow !== 1'b0) begin
                failures++;
                $display("FAIL cap400_bit%0d: got vo,a=%b%b ovf=%b required %b ovf=0",
                         i, bus.valid_out, bus.a, bus.overflow, exp_va);
            end
        end
        drive(1'b1, 1'b0, 1'b0);
        exp_va = sb.pop_front();
        checks++;
        if ({bus.valid_out, bus.a} !== exp_va || bus.overflow !== 1'b0 || bus.token_count !== 16'd200 || bus.odd_error !== 1'b0) begin
            failures++;
            $display("FAIL cap400_final: got vo,a=%b%b ovf=%b odd=%b cnt=%0d required %b ovf=0 odd=0 cnt=200",
                     bus.valid_out, bus.a, bus.overflow, bus.odd_error, bus.token_count, exp_va);
        end

        do_reset();
        for (int i = 0; i < 401; i++) begin
            drive(1'b1, 1'b1, logic'(i % 2));
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va || bus.overflow !== (i == 400)) begin
                failures++;
                $display("FAIL cap401_bit%0d: got vo,a=%b%b ovf=%b required %b ovf=%b",
                         i, bus.valid_out, bus.a, bus.overflow, exp_va, (i == 400));
            end
        end
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_va = sb.pop_front();
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.token_count !== 16'd200) begin
            failures++;
            $display("FAIL cap401_sticky: got ovf=%b cnt=%0d required ovf=1 cnt=200", bus.overflow, bus.token_count);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2:0] bseq;
        logic [2:0] aseq;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, logic'(i % 2));
        end
        do_reset();
        checks++;
        if (bus.odd_error !== 1'b0 || bus.token_count !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset: got odd=%b cnt=%0d required odd=0 cnt=0", bus.odd_error, bus.token_count);
        end
        bseq = 3'b110;
        aseq = 3'b010;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bseq[2-i], aseq[2-i]);
            exp_va = sb.pop_front();
            checks++;
            if ({bus.valid_out, bus.a} !== exp_va) begin
                failures++;
                $display("FAIL midrun_bit%0d: got vo,a=%b%b required %b", i, bus.valid_out, bus.a, exp_va);
            end
        end
        checks++;
        if (bus.token_count !== 16'd1 || bus.odd_error !== 1'b0) begin
            failures++;
            $display("FAIL midrun_final: got cnt=%0d odd=%b required cnt=1 odd=0", bus.token_count, bus.odd_error);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int p = 0; p < 17; p++) begin
            for (int i = 0; i < 3; i++) begin
                drive4(1'b1, logic'(i != 2), logic'(i == 1));
                exp_va = sb.pop_front();
                checks++;
                if ({bus4.valid_out, bus4.a} !== exp_va) begin
                    failures++;
                    $display("FAIL wrap_p%0d_b%0d: got vo,a=%b%b required %b", p, i, bus4.valid_out, bus4.a, exp_va);
                end
            end
        end
        checks++;
        if (bus4.token_count !== 4'd1 || bus4.odd_error !== 1'b0 || bus4.overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_final: got cnt=%0d odd=%b ovf=%b required cnt=1 odd=0 ovf=0",
                     bus4.token_count, bus4.odd_error, bus4.overflow);
        end
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.b         = 1'b0;
        bus4.valid_in = 1'b0;
        bus4.b        = 1'b0;
        test_reset();
        test_canonical();
        test_odd_run();
        test_valid_gaps();
        test_capacity();
        test_reset_mid_run();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/halve_tokens.md
Name: halve_tokens

Overview:
- Serial decoder for the token-doubling stream format, where every '1' token in the source stream appears as two '1's on the line.
- Consumes the doubled bit stream and emits one token per received pair, in canonical form: the token appears on the second bit of each pair.
- Detects malformed runs (odd length) and runs longer than the doubler's guaranteed capacity; both errors are sticky.
- Keeps a running count of decoded tokens.
- Sits at the receiving end of the serial token link, after the doubling stage.

Parameters:
- MAX_TOKENS, 200: maximum consecutive tokens a legal run may carry. Longest legal run of '1's is 2*MAX_TOKENS.
- CNT_W, 16: width of the decoded-token counter.

Ports:
- clk, input, 1: clock, all state on rising edge.
- rst, input, 1: synchronous active-high reset.
- valid_in, input, 1: qualifies b. Cycles with valid_in=0 are not part of the stream.
- b, input, 1: doubled token stream bit.
- valid_out, output, 1: qualifies a.
- a, output, 1: decoded token stream bit.
- odd_error, output, 1: sticky; a run of '1's ended with odd length.
- overflow, output, 1: sticky; a run exceeded 2*MAX_TOKENS '1's.
- token_count, output, CNT_W: number of tokens emitted on a since reset, modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All outputs become 0: valid_out, a, odd_error, overflow, token_count.
  - Internal parity and run_len are cleared.
  - rst has priority over every other event.
- Stream cycle: a cycle with valid_in=1. Idle cycles (valid_in=0) change no internal state, and the next edge drives valid_out=0, a=0.
  - Idle cycles do not terminate a run: 1, idle, 1 is a run of length 2.
- Latency: registered, 1 cycle. valid_out(t+1)=valid_in(t).
- State per stream cycle:
  - parity: 1 bit, the position of the current bit within its pair.
  - run_len: counts consecutive '1's, saturating at 2*MAX_TOKENS+1. Width is sufficient to hold 2*MAX_TOKENS+1.
- Stream cycle with b=1:
  - a(t+1) = parity. A token is emitted on the second, fourth, ... '1' of the run.
  - parity toggles.
  - run_len increments (saturating).
  - If parity=1, token_count increments, wrapping from 2^CNT_W-1 to 0.
  - If run_len = 2*MAX_TOKENS before this increment, overflow <= 1.
- Stream cycle with b=0:
  - a(t+1) = 0.
  - If parity=1, odd_error <= 1.
  - parity and run_len are cleared.
- Error handling:
  - odd_error and overflow, once set, hold until rst.
  - Decoding continues normally after either error; errors never suppress a or token_count.
- Boundaries:
  - A run of exactly 2*MAX_TOKENS '1's: no overflow.
  - The (2*MAX_TOKENS+1)-th consecutive '1': overflow asserts on the following edge.
  - A run still open at reset is discarded; no error is raised.
  - The first '1' after reset is the first bit of a pair.
- No state machine beyond the parity bit, run_len and the sticky flags. No backpressure; the block always accepts input.

Test Plan:
1. Canonical decode:
   - Stimulus: valid_in=1 continuously, b=11011011110111111001111110 (left bit first).
   - Required: a, one cycle later, = 01001001010010101000101010.
   - Required after the last bit: token_count=10, odd_error=0, overflow=0.
2. Odd run:
   - Stimulus: b=1110.
   - Required: a=0100; odd_error rises on the edge after the 0 is sampled and stays 1 for 20 more cycles of b=0.
   - Required: rst clears odd_error to 0.
3. Valid gaps:
   - Stimulus: b=1 (valid), 3 idle cycles, b=1 (valid), b=0 (valid).
   - Required: exactly one a=1, coincident with valid_out=1 one cycle after the second valid '1'.
   - Required: valid_out=0 during the gap; odd_error=0; token_count=1.
4. Capacity:
   - Stimulus: 400 consecutive '1's then 0.
   - Required: overflow=0, token_count=200.
   - Stimulus: after rst, 401 '1's.
   - Required: overflow=1 from the edge after the 401st '1'; it remains 1 after 50 zeros.
5. Reset mid-run:
   - Stimulus: b=111, rst for one cycle, then b=110.
   - Required: after rst, odd_error=0 and token_count=0.
   - Required: the final 110 yields a=010 and token_count=1.
6. Counter wrap:
   - Stimulus: CNT_W=4, 17 pairs of '1's each separated by a 0.
   - Required: token_count=1 at the end; no errors.
